// File: rtl/ctrl_encode_def.sv
// Shared fetch-sequencer definitions: state encodings and architectural constants.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ctrl_encode_def;

    // Fetch controller states. FS_TRAP is only reachable when the misaligned
    // redirect trap is built in.
    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_TRAP  = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Default architectural PC after reset.
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry {pc, instr} holding buffer for a fetch response that arrives while IF/ID is occupied.
// Latency: load/drain/flush take effect on the next rising edge.
// Backpressure: none itself; the sequencer only loads when the buffer is empty and drains on id_ready.
//
// Ports: clk/rst (async active-high), i_load writes {i_pc, i_instr}, i_drain empties after the
// owner has consumed o_pc/o_instr, i_flush discards the entry (wins over load), o_valid/o_pc/o_instr.
module fetch_skid_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_drain,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr
);
    import ctrl_encode_def::*;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= XLEN'(NOP_INSTR);
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
                r_pc    <= i_pc;
                r_instr <= i_instr;
            end else if (i_drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns pc_q, issues one outstanding imem fetch, presents instructions to IF/ID.
// Latency: gnt -> next address on imem_addr the following cycle; rvalid -> if_valid next cycle (1 instr / 2 cycles peak).
// Backpressure: id_ready low holds if_* stable; a response arriving meanwhile parks in a skid entry (HOLD, no new fetch).
//
// Ports: clk/rst (async active-high); redirect_valid/redirect_pc from EX (highest priority, every cycle);
// id_ready from decode; imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata memory handshake;
// if_valid/if_pc/if_instr to IF/ID; fetch_pc = pc_q for debug.
// Build option FETCH_MISALIGN_TRAP_EN: adds misalign_trap/misalign_pc; a redirect with pc[1:0]!=0 parks the
// sequencer in FS_TRAP until reset or an aligned redirect. Without it, redirect_pc[1:0] is forced to zero.
module fetch_sequencer #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = ctrl_encode_def::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = ctrl_encode_def::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            misalign_trap,
    output logic [XLEN-1:0] misalign_pc,
`endif
    output logic [XLEN-1:0] fetch_pc
);
    import ctrl_encode_def::*;

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_req_pc;
    logic            r_kill;
    logic            w_kill_nxt;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_instr;

    logic            w_imem_req;
    logic            w_req_ld;
    logic            w_ld_rsp;
    logic            w_ld_buf;
    logic            w_drain;
    logic            w_slot_free;
    logic [XLEN-1:0] w_redirect_tgt;
    logic            w_buf_vld;
    logic [XLEN-1:0] w_buf_pc;
    logic [XLEN-1:0] w_buf_instr;

    // Instructions are word aligned; the low two target bits never reach imem_addr.
    assign w_redirect_tgt = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
    assign w_slot_free    = !r_if_valid || id_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            w_misaligned;
    logic            r_trap;
    logic [XLEN-1:0] r_trap_pc;

    assign w_misaligned = |redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trap    <= 1'b0;
            r_trap_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_trap <= w_misaligned;
            if (w_misaligned) begin
                r_trap_pc <= redirect_pc;
            end
        end
    end

    assign misalign_trap = r_trap;
    assign misalign_pc   = r_trap_pc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FS_FETCH;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_pc_nxt    = r_pc;
        w_imem_req  = 1'b0;
        w_req_ld    = 1'b0;
        w_ld_rsp    = 1'b0;
        w_ld_buf    = 1'b0;
        w_drain     = 1'b0;

        case (r_state)
            FS_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_gnt) begin
                    w_req_ld    = 1'b1;
                    w_pc_nxt    = r_pc + XLEN'(4);
                    w_state_nxt = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = FS_FETCH;
                    if (r_kill) begin
                        w_kill_nxt = 1'b0;
                    end else if (w_slot_free) begin
                        w_ld_rsp = 1'b1;
                    end else begin
                        w_ld_buf    = 1'b1;
                        w_state_nxt = FS_HOLD;
                    end
                end
            end
            FS_HOLD: begin
                if (id_ready && w_buf_vld) begin
                    w_drain     = 1'b1;
                    w_state_nxt = FS_FETCH;
                end
            end
            default: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                // A killed request may still be in flight while trapped; retire it here.
                if (imem_rvalid) begin
                    w_kill_nxt = 1'b0;
                end
`else
                w_state_nxt = FS_FETCH;
`endif
            end
        endcase

        // Redirect overrides everything above. Any request granted but not yet
        // answered becomes stale and is marked for killing.
        if (redirect_valid) begin
            w_pc_nxt = w_redirect_tgt;
            w_ld_rsp = 1'b0;
            w_ld_buf = 1'b0;
            w_drain  = 1'b0;
            case (r_state)
                FS_FETCH: begin
                    if (imem_gnt) begin
                        w_state_nxt = FS_WAIT;
                        w_kill_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = FS_FETCH;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        w_state_nxt = FS_FETCH;
                        w_kill_nxt  = 1'b0;
                    end else begin
                        w_kill_nxt  = 1'b1;
                    end
                end
                FS_HOLD: begin
                    w_state_nxt = FS_FETCH;
                end
                default: begin
                    // Leaving the trap: wait out a still-outstanding killed response first.
                    w_kill_nxt  = r_kill && !imem_rvalid;
                    w_state_nxt = (r_kill && !imem_rvalid) ? FS_WAIT : FS_FETCH;
                end
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_misaligned) begin
                w_state_nxt = FS_TRAP;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_pc <= RESET_PC;
        end else if (w_req_ld) begin
            r_req_pc <= r_pc;
        end
    end

    // IF/ID output register: redirect flush, then fresh response, then skid drain, then consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= RESET_PC;
            r_if_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
        end else if (w_ld_rsp) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_req_pc;
            r_if_instr <= imem_rdata;
        end else if (w_drain) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= w_buf_pc;
            r_if_instr <= w_buf_instr;
        end else if (id_ready && r_if_valid) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
        end
    end

    fetch_skid_buf #(
        .XLEN (XLEN)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_ld_buf),
        .i_drain (w_drain),
        .i_flush (redirect_valid),
        .i_pc    (r_req_pc),
        .i_instr (imem_rdata),
        .o_valid (w_buf_vld),
        .o_pc    (w_buf_pc),
        .o_instr (w_buf_instr)
    );

    // The state register idles in FS_FETCH during reset, so the request is gated by rst itself.
    assign imem_req  = w_imem_req && !rst;
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign fetch_pc  = r_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] fetch_pc;

    int n_checks = 0;
    int n_errors = 0;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .fetch_pc       (fetch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start a new cycle: inputs change just after the falling edge, outputs are
    // sampled 1 time unit later, well before the next rising edge.
    task automatic drive(input logic rv, input logic [31:0] rpc, input logic idr,
                         input logic g, input logic rvl, input logic [31:0] rd);
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = idr;
        imem_gnt       = g;
        imem_rvalid    = rvl;
        imem_rdata     = rd;
        #1;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        #2;
        n_checks++;
        if ({imem_req, if_valid} !== 2'b00) begin
            n_errors++; $display("FAIL reset_req_valid: got req=%b valid=%b, want 0 0", imem_req, if_valid);
        end
        n_checks++;
        if ({if_pc, if_instr, fetch_pc} !== {RPC, NOP, RPC}) begin
            n_errors++; $display("FAIL reset_values: got if_pc=%h if_instr=%h fetch_pc=%h", if_pc, if_instr, fetch_pc);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, RPC}) begin
            n_errors++; $display("FAIL reset_first_req: got req=%b addr=%h, want 1 %h", imem_req, imem_addr, RPC);
        end
    endtask

    task automatic test_zero_wait;
        logic [31:0] d [4];
        apply_reset;
        for (int k = 0; k < 4; k++) begin
            d[k] = $urandom;
            drive(1'b0, '0, 1'b1, (k < 3), 1'b0, '0);
            n_checks++;
            if ({imem_req, imem_addr} !== {1'b1, 32'(4 * k)}) begin
                n_errors++; $display("FAIL zw_addr%0d: got req=%b addr=%h, want 1 %h", k, imem_req, imem_addr, 4 * k);
            end
            if (k > 0) begin
                n_checks++;
                if ({if_valid, if_pc, if_instr} !== {1'b1, 32'(4 * (k - 1)), d[k-1]}) begin
                    n_errors++; $display("FAIL zw_out%0d: got v=%b pc=%h instr=%h, want 1 %h %h",
                                         k, if_valid, if_pc, if_instr, 4 * (k - 1), d[k-1]);
                end
            end
            if (k < 3) begin
                drive(1'b0, '0, 1'b1, 1'b0, 1'b1, d[k]);
                n_checks++;
                if ({imem_req, if_valid, if_instr} !== {1'b0, 1'b0, NOP}) begin
                    n_errors++; $display("FAIL zw_gap%0d: got req=%b v=%b instr=%h, want 0 0 %h", k, imem_req, if_valid, if_instr, NOP);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] a;
        a = $urandom;
        apply_reset;
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, a);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        n_checks++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'h0, a, 32'h4}) begin
            n_errors++; $display("FAIL bp_first: got v=%b pc=%h instr=%h addr=%h", if_valid, if_pc, if_instr, imem_addr);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h0050_0093);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
            n_checks++;
            if ({imem_req, if_valid, if_pc, if_instr} !== {1'b0, 1'b1, 32'h0, a}) begin
                n_errors++; $display("FAIL bp_hold%0d: got req=%b v=%b pc=%h instr=%h, want 0 1 0 %h",
                                     i, imem_req, if_valid, if_pc, if_instr, a);
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if ({imem_req, imem_addr, if_valid, if_pc, if_instr} !== {1'b1, 32'h8, 1'b1, 32'h4, 32'h0050_0093}) begin
            n_errors++; $display("FAIL bp_release: got req=%b addr=%h v=%b pc=%h instr=%h, want 1 8 1 4 00500093",
                                 imem_req, imem_addr, if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_redirect_wait;
        logic [31:0] d;
        d = $urandom;
        apply_reset;
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if ({imem_req, if_valid} !== 2'b00) begin
            n_errors++; $display("FAIL rw_wait: got req=%b v=%b, want 0 0", imem_req, if_valid);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h100, 1'b0}) begin
            n_errors++; $display("FAIL rw_refetch: got req=%b addr=%h v=%b instr=%h, want 1 100 0", imem_req, imem_addr, if_valid, if_instr);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, d);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h100, d}) begin
            n_errors++; $display("FAIL rw_deliver: got v=%b pc=%h instr=%h, want 1 100 %h", if_valid, if_pc, if_instr, d);
        end
    endtask

    task automatic test_redirect_gnt;
        logic [31:0] d;
        d = $urandom;
        apply_reset;
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, $urandom);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, $urandom);
        drive(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if ({imem_req, imem_addr, if_valid, if_pc} !== {1'b1, 32'h8, 1'b1, 32'h4}) begin
            n_errors++; $display("FAIL rg_pre: got req=%b addr=%h v=%b pc=%h, want 1 8 1 4", imem_req, imem_addr, if_valid, if_pc);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h0BAD_0BAD);
        n_checks++;
        if ({imem_req, if_valid} !== 2'b00) begin
            n_errors++; $display("FAIL rg_kill: got req=%b v=%b, want 0 0", imem_req, if_valid);
        end
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h200, 1'b0}) begin
            n_errors++; $display("FAIL rg_refetch: got req=%b addr=%h v=%b instr=%h, want 1 200 0", imem_req, imem_addr, if_valid, if_instr);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, d);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h200, d}) begin
            n_errors++; $display("FAIL rg_deliver: got v=%b pc=%h instr=%h, want 1 200 %h", if_valid, if_pc, if_instr, d);
        end
    endtask

    task automatic test_wrap_reset;
        logic [31:0] d;
        d = $urandom;
        apply_reset;
        drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_errors++; $display("FAIL wr_latency: got req=%b addr=%h, want 1 fffffffc", imem_req, imem_addr);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, d);
        n_checks++;
        if (fetch_pc !== 32'h0) begin
            n_errors++; $display("FAIL wr_wrap: got fetch_pc=%h, want 0", fetch_pc);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if ({fetch_pc, if_valid, if_pc, if_instr} !== {32'h4, 1'b1, 32'hFFFF_FFFC, d}) begin
            n_errors++; $display("FAIL wr_pre_rst: got fetch_pc=%h v=%b pc=%h instr=%h", fetch_pc, if_valid, if_pc, if_instr);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({imem_req, if_valid, if_pc, if_instr, fetch_pc} !== {1'b0, 1'b0, RPC, NOP, RPC}) begin
            n_errors++; $display("FAIL wr_async_rst: got req=%b v=%b pc=%h instr=%h fetch_pc=%h",
                                 imem_req, if_valid, if_pc, if_instr, fetch_pc);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
        rst = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if ({imem_req, imem_addr, if_valid, if_instr} !== {1'b1, RPC, 1'b0, NOP}) begin
            n_errors++; $display("FAIL wr_late_rvalid: got req=%b addr=%h v=%b instr=%h", imem_req, imem_addr, if_valid, if_instr);
        end
    endtask

    // Random traffic against a transaction-level model: every granted address must follow the
    // program-order PC (reset, +4, or a redirect target), and the IF/ID stream must equal the
    // ordered list of responses whose request was not overtaken by a redirect.
    task automatic test_random;
        logic [31:0] exp_pc;
        logic [31:0] q_pc [$];
        logic [31:0] q_in [$];
        bit          mem_busy;
        bit          pend_alive;
        logic [31:0] pend_pc;
        int unsigned mem_wait;
        bit          prev_stall;
        logic [31:0] prev_pc, prev_in;
        int          delivered;
        logic        rv, idr, g, rvl, drain;
        logic [31:0] rpc, rd;
        apply_reset;
        exp_pc = RPC; mem_busy = 0; pend_alive = 0; pend_pc = '0; mem_wait = 0;
        prev_stall = 0; prev_pc = '0; prev_in = '0; delivered = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            drain = (cyc >= 3800);
            rv  = !drain && ($urandom_range(0, 15) == 0);
            rpc = $urandom_range(0, 4095);
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            idr = drain || ($urandom_range(0, 3) != 0);
            g   = !drain && ($urandom_range(0, 3) != 0);
            rd  = $urandom;
            rvl = 1'b0;
            if (mem_busy) begin
                if (mem_wait == 0) rvl = 1'b1;
                else mem_wait--;
            end
            drive(rv, rpc, idr, g, rvl, rd);

            if (if_valid) begin
                n_checks++;
                if (q_pc.size() == 0) begin
                    n_errors++; $display("FAIL rnd_spurious cyc %0d: got pc=%h instr=%h, want no valid", cyc, if_pc, if_instr);
                end else begin
                    n_checks++;
                    if ({if_pc, if_instr} !== {q_pc[0], q_in[0]}) begin
                        n_errors++; $display("FAIL rnd_stream cyc %0d: got pc=%h instr=%h, want %h %h",
                                             cyc, if_pc, if_instr, q_pc[0], q_in[0]);
                    end
                    if (idr && !rv) begin
                        void'(q_pc.pop_front()); void'(q_in.pop_front());
                        delivered++;
                    end
                end
            end else begin
                n_checks++;
                if (if_instr !== NOP) begin
                    n_errors++; $display("FAIL rnd_nop cyc %0d: got instr=%h, want %h", cyc, if_instr, NOP);
                end
            end
            if (prev_stall) begin
                n_checks++;
                if ({if_valid, if_pc, if_instr} !== {1'b1, prev_pc, prev_in}) begin
                    n_errors++; $display("FAIL rnd_stall cyc %0d: got v=%b pc=%h instr=%h, want 1 %h %h",
                                         cyc, if_valid, if_pc, if_instr, prev_pc, prev_in);
                end
            end
            prev_stall = if_valid && !idr && !rv;
            prev_pc = if_pc; prev_in = if_instr;

            if (imem_req) begin
                n_checks++;
                if (mem_busy) begin
                    n_errors++; $display("FAIL rnd_outstanding cyc %0d: got req=1 with a fetch in flight, want 0", cyc);
                end
            end
            if (imem_req && g) begin
                n_checks++;
                if (imem_addr !== exp_pc) begin
                    n_errors++; $display("FAIL rnd_addr cyc %0d: got addr=%h, want %h", cyc, imem_addr, exp_pc);
                end
                pend_pc = exp_pc; pend_alive = 1; mem_busy = 1;
                mem_wait = $urandom_range(0, 2);
                exp_pc = exp_pc + 32'd4;
            end
            if (rvl) begin
                mem_busy = 0;
                if (pend_alive && !rv) begin
                    q_pc.push_back(pend_pc); q_in.push_back(rd);
                end
                pend_alive = 0;
            end
            if (rv) begin
                exp_pc = rpc & ~32'h3;
                pend_alive = 0;
                q_pc.delete(); q_in.delete();
            end
        end
        n_checks++;
        if (q_pc.size() != 0) begin
            n_errors++; $display("FAIL rnd_drain: got %0d undelivered instructions, want 0", q_pc.size());
        end
        n_checks++;
        if (delivered < 50) begin
            n_errors++; $display("FAIL rnd_progress: got %0d delivered, want at least 50", delivered);
        end
    endtask

    initial begin
        test_reset;
        test_zero_wait;
        test_backpressure;
        test_redirect_wait;
        test_redirect_gnt;
        test_wrap_reset;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
